// File: rtl/cnt_step_arbiter.sv
// Two-port round-robin command arbiter wrapped around the saturating signed step counter.
// Each accepted command steps the counter N times up or down, then pulses done with a saturation flag.
module cnt_step_arbiter #(
    parameter int RST_VAL = -50,
    parameter int MIN_VAL = -230,
    parameter int MAX_VAL = 235,
    parameter int INV_VAL = -11,
    parameter int UP_STEP = 5,
    parameter int DN_STEP = 9,
    parameter int LEN_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              cmd_valid,
    output logic [1:0]              cmd_ready,
    input  logic                    cmd_dir0,
    input  logic                    cmd_dir1,
    input  logic [LEN_W-1:0]        cmd_len0,
    input  logic [LEN_W-1:0]        cmd_len1,
    output logic signed [9:0]       cnt,
    output logic                    busy,
    output logic                    done,
    output logic                    done_id,
    output logic                    done_sat
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic signed [10:0] UP_SKIP_AT = 11'(INV_VAL - UP_STEP);
    localparam logic signed [10:0] UP_LIMIT   = 11'(MAX_VAL - UP_STEP);
    localparam logic signed [10:0] DN_SKIP_AT = 11'(INV_VAL + DN_STEP);
    localparam logic signed [10:0] DN_LIMIT   = 11'(MIN_VAL + DN_STEP);
    localparam logic signed [10:0] UP_1       = 11'(UP_STEP);
    localparam logic signed [10:0] UP_2       = 11'(2 * UP_STEP);
    localparam logic signed [10:0] DN_1       = 11'(DN_STEP);
    localparam logic signed [10:0] DN_2       = 11'(2 * DN_STEP);

    // One counter step in 11-bit signed; a step that would land on INV_VAL jumps over it.
    function automatic logic signed [9:0] step_val(input logic signed [9:0] c, input logic up);
        logic signed [10:0] w;
        logic signed [10:0] n;
        w = {c[9], c};
        n = w;
        if (up) begin
            if (w == UP_SKIP_AT)     n = w + UP_2;
            else if (w <= UP_LIMIT)  n = w + UP_1;
        end else begin
            if (w == DN_SKIP_AT)     n = w - DN_2;
            else if (w >= DN_LIMIT)  n = w - DN_1;
        end
        return 10'(n);
    endfunction

    function automatic logic step_sat(input logic signed [9:0] c, input logic up);
        logic signed [10:0] w;
        w = {c[9], c};
        if (up) return (w != UP_SKIP_AT) && (w > UP_LIMIT);
        else    return (w != DN_SKIP_AT) && (w < DN_LIMIT);
    endfunction

    state_t             state_q, state_d;
    logic signed [9:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               id_q, id_d;
    logic               sat_q, sat_d;
    logic               last_q, last_d;
    logic               gnt_id;
    logic               gnt_dir;
    logic [LEN_W-1:0]   gnt_len;

    // The first step is taken on the accept edge so cnt shows k steps during RUN cycle k.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        id_d      = id_q;
        sat_d     = sat_q;
        last_d    = last_q;
        cmd_ready = 2'b00;
        gnt_id    = 1'b0;
        gnt_dir   = 1'b0;
        gnt_len   = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid[0] && (!cmd_valid[1] || last_q)) cmd_ready = 2'b01;
                else if (cmd_valid[1])                          cmd_ready = 2'b10;
                gnt_id  = cmd_ready[1];
                gnt_dir = gnt_id ? cmd_dir1 : cmd_dir0;
                gnt_len = gnt_id ? cmd_len1 : cmd_len0;
                if (cmd_ready != 2'b00) begin
                    id_d   = gnt_id;
                    last_d = gnt_id;
                    dir_d  = gnt_dir;
                    rem_d  = gnt_len;
                    if (gnt_len == '0) begin
                        state_d = ST_DONE;
                        sat_d   = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = step_val(cnt_q, gnt_dir);
                        sat_d   = step_sat(cnt_q, gnt_dir);
                    end
                end
            end
            ST_RUN: begin
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = step_val(cnt_q, dir_q);
                    if (step_sat(cnt_q, dir_q)) sat_d = 1'b1;
                    rem_d = rem_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 10'(RST_VAL);
            id_q    <= 1'b0;
            sat_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            sat_q   <= sat_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        dir_q <= dir_d;
    end

    assign cnt      = cnt_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign done_id  = done & id_q;
    assign done_sat = done & sat_q;

endmodule
